// File: rtl/cbfp_block_norm.sv
// Block-floating-point normaliser: ping-pong buffers BLK_BEATS beats, finds the block-wide minimum redundant-sign-bit count, replays the block shifted to OUT_WIDTH.
// Latency: first output beat one cycle after the last input beat of a block; no backpressure, a fill never overtakes the drain.
module cbfp_block_norm #(
  parameter int IN_WIDTH    = 23,
  parameter int OUT_WIDTH   = 13,
  parameter int LANES       = 16,
  parameter int BLK_BEATS   = 4,
  parameter int SHIFT_WIDTH = 5,
  parameter int SEPARATE_RI = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 din_valid,
  input  logic [LANES-1:0][IN_WIDTH-1:0]       din_real,
  input  logic [LANES-1:0][IN_WIDTH-1:0]       din_imag,
  output logic                                 dout_valid,
  output logic                                 dout_sob,
  output logic [LANES-1:0][OUT_WIDTH-1:0]      dout_real,
  output logic [LANES-1:0][OUT_WIDTH-1:0]      dout_imag,
  output logic [SHIFT_WIDTH-1:0]               shift_re,
  output logic [SHIFT_WIDTH-1:0]               shift_im
);

  localparam int CW = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLK_BEATS - 1);
  localparam logic [SHIFT_WIDTH-1:0] MAG_MAX = SHIFT_WIDTH'(IN_WIDTH - 1);
  localparam int DROP = IN_WIDTH - OUT_WIDTH;

  typedef logic [LANES-1:0][IN_WIDTH-1:0] beat_t;

  beat_t mem_re [2][BLK_BEATS];
  beat_t mem_im [2][BLK_BEATS];

  logic                   fill_bank;
  logic [CW-1:0]          beat_cnt;
  logic [SHIFT_WIDTH-1:0] min_re, min_im;
  logic [SHIFT_WIDTH-1:0] exp_re, exp_im;
  logic                   drain_act;
  logic                   drain_bank;
  logic [CW-1:0]          drain_cnt;
  logic [SHIFT_WIDTH-1:0] bmin_re, bmin_im;
  logic [SHIFT_WIDTH-1:0] nmin_re, nmin_im;
  logic                   last_fill;

  // Sign-bit run length minus one; 0 and -1 both give IN_WIDTH-1.
  function automatic logic [SHIFT_WIDTH-1:0] mag(input logic [IN_WIDTH-1:0] x);
    logic [SHIFT_WIDTH-1:0] m;
    logic                   run;
    m   = '0;
    run = 1'b1;
    for (int i = IN_WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[IN_WIDTH-1])) m = m + 1'b1;
      else run = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] norm(input logic [IN_WIDTH-1:0] x,
                                                input logic [SHIFT_WIDTH-1:0] s);
    logic signed [IN_WIDTH-1:0] t;
    t = $signed(x) <<< s;
    return OUT_WIDTH'(t >>> DROP);
  endfunction

  always_comb begin
    bmin_re = MAG_MAX;
    bmin_im = MAG_MAX;
    for (int l = 0; l < LANES; l++) begin
      if (mag(din_real[l]) < bmin_re) bmin_re = mag(din_real[l]);
      if (mag(din_imag[l]) < bmin_im) bmin_im = mag(din_imag[l]);
    end
    if (SEPARATE_RI == 0) begin
      if (bmin_im < bmin_re) bmin_re = bmin_im;
      bmin_im = bmin_re;
    end
    nmin_re = (bmin_re < min_re) ? bmin_re : min_re;
    nmin_im = (bmin_im < min_im) ? bmin_im : min_im;
  end

  assign last_fill = din_valid && (beat_cnt == LAST);

  always_ff @(posedge clk) begin
    if (din_valid) begin
      mem_re[fill_bank][beat_cnt] <= din_real;
      mem_im[fill_bank][beat_cnt] <= din_imag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_bank  <= 1'b0;
      beat_cnt   <= '0;
      min_re     <= MAG_MAX;
      min_im     <= MAG_MAX;
      exp_re     <= '0;
      exp_im     <= '0;
      drain_act  <= 1'b0;
      drain_bank <= 1'b0;
      drain_cnt  <= '0;
      dout_valid <= 1'b0;
      dout_sob   <= 1'b0;
      dout_real  <= '0;
      dout_imag  <= '0;
      shift_re   <= '0;
      shift_im   <= '0;
    end else begin
      if (din_valid) begin
        if (last_fill) begin
          exp_re    <= nmin_re;
          exp_im    <= nmin_im;
          fill_bank <= ~fill_bank;
          beat_cnt  <= '0;
          min_re    <= MAG_MAX;
          min_im    <= MAG_MAX;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          min_re   <= nmin_re;
          min_im   <= nmin_im;
        end
      end

      // Exponent registers are read here before a coincident swap updates them.
      if (drain_act) begin
        dout_valid <= 1'b1;
        dout_sob   <= (drain_cnt == '0);
        shift_re   <= exp_re;
        shift_im   <= exp_im;
        for (int l = 0; l < LANES; l++) begin
          dout_real[l] <= norm(mem_re[drain_bank][drain_cnt][l], exp_re);
          dout_imag[l] <= norm(mem_im[drain_bank][drain_cnt][l], exp_im);
        end
        drain_cnt <= (drain_cnt == LAST) ? '0 : drain_cnt + 1'b1;
      end else begin
        dout_valid <= 1'b0;
        dout_sob   <= 1'b0;
      end

      if (last_fill) begin
        drain_act  <= 1'b1;
        drain_bank <= fill_bank;
        drain_cnt  <= '0;
      end else if (drain_act && (drain_cnt == LAST)) begin
        drain_act <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cbfp_block_norm.sv
// Bench for cbfp_block_norm: directed and random blocks checked against an arithmetic reference model.
module tb_cbfp_block_norm;
  localparam int IW = 23;
  localparam int OW = 13;
  localparam int LN = 16;
  localparam int BB = 4;
  localparam int SW = 5;
  localparam int D  = IW - OW;

  logic clk = 1'b0;
  logic rst;
  logic din_valid;
  logic [LN-1:0][IW-1:0] din_real, din_imag;
  logic dout_valid, dout_sob;
  logic [LN-1:0][OW-1:0] dout_real, dout_imag;
  logic [SW-1:0] shift_re, shift_im;
  logic sep_valid, sep_sob;
  logic [LN-1:0][OW-1:0] sep_real, sep_imag;
  logic [SW-1:0] sep_sre, sep_sim;

  cbfp_block_norm #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LANES(LN), .BLK_BEATS(BB),
                    .SHIFT_WIDTH(SW), .SEPARATE_RI(0)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_real(din_real), .din_imag(din_imag),
    .dout_valid(dout_valid), .dout_sob(dout_sob), .dout_real(dout_real), .dout_imag(dout_imag),
    .shift_re(shift_re), .shift_im(shift_im));

  cbfp_block_norm #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LANES(LN), .BLK_BEATS(BB),
                    .SHIFT_WIDTH(SW), .SEPARATE_RI(1)) dut_sep (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_real(din_real), .din_imag(din_imag),
    .dout_valid(sep_valid), .dout_sob(sep_sob), .dout_real(sep_real), .dout_imag(sep_imag),
    .shift_re(sep_sre), .shift_im(sep_sim));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    logic sob;
    logic [SW-1:0] sre;
    logic [SW-1:0] sim;
    logic [LN-1:0][OW-1:0] re;
    logic [LN-1:0][OW-1:0] im;
  } out_beat_t;

  out_beat_t cap[$];
  out_beat_t cap_sep[$];

  always begin
    out_beat_t o;
    @(posedge clk);
    #1;
    if (dout_valid) begin
      o.cyc = cyc; o.sob = dout_sob; o.sre = shift_re; o.sim = shift_im;
      o.re = dout_real; o.im = dout_imag;
      cap.push_back(o);
    end
    if (sep_valid) begin
      o.cyc = cyc; o.sob = sep_sob; o.sre = sep_sre; o.sim = sep_sim;
      o.re = sep_real; o.im = sep_imag;
      cap_sep.push_back(o);
    end
  end

  int blk_re [2][BB][LN];
  int blk_im [2][BB][LN];
  int last_edge [2];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: smallest signed width that holds v determines the redundant sign bits.
  function automatic int mag_of(input int v);
    for (int w = 1; w <= IW; w++)
      if (v >= -(1 << (w - 1)) && v < (1 << (w - 1))) return IW - w;
    return 0;
  endfunction

  // Reference: floor(v * 2^s / 2^D).
  function automatic int norm_of(input int v, input int s);
    int q;
    q = v * (1 << s);
    if (q >= 0) return q / (1 << D);
    return -((-q + (1 << D) - 1) / (1 << D));
  endfunction

  function automatic logic [LN*OW-1:0] exp_data(input int s, input int b, input bit im, input int sh);
    logic [LN*OW-1:0] e;
    int t;
    e = '0;
    for (int l = 0; l < LN; l++) begin
      t = norm_of(im ? blk_im[s][b][l] : blk_re[s][b][l], sh);
      e[l*OW +: OW] = t[OW-1:0];
    end
    return e;
  endfunction

  function automatic int rand_val(input int w);
    return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
  endfunction

  task automatic fill_random(input int s, input int wre, input int wim);
    for (int b = 0; b < BB; b++)
      for (int l = 0; l < LN; l++) begin
        blk_re[s][b][l] = rand_val(wre);
        blk_im[s][b][l] = rand_val(wim);
      end
  endtask

  task automatic fill_const(input int s, input int vre, input int vim);
    for (int b = 0; b < BB; b++)
      for (int l = 0; l < LN; l++) begin
        blk_re[s][b][l] = vre;
        blk_im[s][b][l] = vim;
      end
  endtask

  task automatic drive_beat(input int s, input int b);
    @(negedge clk);
    din_valid = 1'b1;
    for (int l = 0; l < LN; l++) begin
      din_real[l] = IW'(blk_re[s][b][l]);
      din_imag[l] = IW'(blk_im[s][b][l]);
    end
  endtask

  task automatic drive_block(input int s, input int gap);
    for (int b = 0; b < BB; b++) begin
      drive_beat(s, b);
      if (b == BB - 1) last_edge[s] = cyc + 1;
      else repeat (gap) begin @(negedge clk); din_valid = 1'b0; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); din_valid = 1'b0; end
  endtask

  task automatic check_block(input int s);
    int sre, sim, sh, t;
    out_beat_t o;
    sre = IW - 1;
    sim = IW - 1;
    for (int b = 0; b < BB; b++)
      for (int l = 0; l < LN; l++) begin
        if (mag_of(blk_re[s][b][l]) < sre) sre = mag_of(blk_re[s][b][l]);
        if (mag_of(blk_im[s][b][l]) < sim) sim = mag_of(blk_im[s][b][l]);
      end
    sh = (sre < sim) ? sre : sim;
    t = 0;
    while ((cap.size() < BB || cap_sep.size() < BB) && t < 4 * BB + 10) begin
      @(negedge clk);
      t++;
    end
    chk("drain_beats", 256'(cap.size() >= BB), 256'(1));
    chk("sep_beats", 256'(cap_sep.size() >= BB), 256'(1));
    if (cap.size() < BB || cap_sep.size() < BB) return;
    for (int b = 0; b < BB; b++) begin
      o = cap.pop_front();
      chk("sob", 256'(o.sob), 256'(b == 0));
      chk("shift_re", 256'(o.sre), 256'(sh));
      chk("shift_im", 256'(o.sim), 256'(sh));
      chk("out_edge", 256'(o.cyc), 256'(last_edge[s] + 1 + b));
      chk("data_re", 256'(o.re), 256'(exp_data(s, b, 1'b0, sh)));
      chk("data_im", 256'(o.im), 256'(exp_data(s, b, 1'b1, sh)));
    end
    o = cap_sep[0];
    chk("sep_sob", 256'(o.sob), 256'(1));
    chk("sep_shift_re", 256'(o.sre), 256'(sre));
    chk("sep_shift_im", 256'(o.sim), 256'(sim));
    chk("sep_data_re", 256'(o.re), 256'(exp_data(s, 0, 1'b0, sre)));
    chk("sep_data_im", 256'(o.im), 256'(exp_data(s, 0, 1'b1, sim)));
    repeat (BB) void'(cap_sep.pop_front());
  endtask

  initial begin
    int t;
    rst = 1'b1;
    din_valid = 1'b0;
    din_real = '0;
    din_imag = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 256'(dout_valid), 256'(0));
    chk("rst_sob", 256'(dout_sob), 256'(0));
    chk("rst_data", 256'({dout_real, dout_imag}), 256'(0));
    chk("rst_shift", 256'({shift_re, shift_im}), 256'(0));
    rst = 1'b0;
    idle(2);

    // All ones: shift 21, outputs 2048.
    fill_const(0, 1, 1);
    drive_block(0, 0); idle(1); check_block(0);

    // One full-scale negative sample forces shift 0.
    fill_const(0, 1000, 1000);
    blk_re[0][2][5] = -4194304;
    drive_block(0, 0); idle(1); check_block(0);

    // All zero: maximum shift.
    fill_const(0, 0, 0);
    drive_block(0, 0); idle(1); check_block(0);

    // Real ones, imag zeros: separate exponents differ.
    fill_const(0, 1, 0);
    drive_block(0, 0); idle(1); check_block(0);

    for (int r = 0; r < 6; r++) begin
      fill_random(0, int'($urandom_range(1, IW)), int'($urandom_range(1, IW)));
      drive_block(0, int'($urandom_range(0, 2)));
      idle(1);
      check_block(0);
    end

    // Two back-to-back blocks with different exponents.
    fill_random(0, 10, 10);
    fill_random(1, 18, 5);
    drive_block(0, 0); drive_block(1, 0); idle(1);
    check_block(0); check_block(1);

    // Input every other cycle.
    fill_random(0, 15, 9);
    drive_block(0, 1); idle(1); check_block(0);

    // Partial block discarded by reset.
    fill_random(0, IW, IW);
    drive_beat(0, 0); drive_beat(0, 1);
    @(negedge clk); din_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    idle(BB + 4);
    chk("rst_partial_no_out", 256'(cap.size()), 256'(0));
    fill_random(0, 6, 4);
    drive_block(0, 0); idle(1); check_block(0);

    // Reset during drain drops dout_valid without a clock edge.
    fill_random(0, 12, 12);
    drive_block(0, 0); idle(1);
    t = 0;
    while (!dout_valid && t < 20) begin @(negedge clk); t++; end
    chk("drain_started", 256'(dout_valid), 256'(1));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_valid_drop", 256'(dout_valid), 256'(0));
    @(negedge clk); rst = 1'b0;
    idle(BB + 2);
    cap.delete();
    cap_sep.delete();

    fill_random(0, 20, 14);
    drive_block(0, 0); idle(1); check_block(0);

    idle(10);
    chk("no_spurious", 256'(cap.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
